// File: rtl/mux_rr_feeder.sv
// Round-robin 4:1 valid/ready arbiter with one output register stage that feeds out_sel to the
// downstream data mux. Optional per-channel grant counters are enabled by MUX_RR_FEEDER_CNT_EN.
module mux_rr_feeder #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
`ifdef MUX_RR_FEEDER_CNT_EN
  output logic [31:0]  grant_cnt,
`endif
  output logic [1:0]   out_sel
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e         r_state, w_state_next;
  logic [1:0]     r_ptr;
  logic [1:0]     r_out_sel;
  logic [W-1:0]   r_out_data;
  logic [1:0]     w_grant;
  logic           w_found;
  logic           w_load;
  logic [W-1:0]   w_win_data;

  // Search ptr+1 .. ptr+4 (mod 4); the last step revisits ptr itself.
  always_comb begin
    w_grant = r_ptr;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!w_found && in_valid[2'(r_ptr + 2'(k))]) begin
        w_found = 1'b1;
        w_grant = 2'(r_ptr + 2'(k));
      end
    end
  end

  // Gated by rst_n so nothing is accepted while reset is held.
  assign w_load   = rst_n && w_found && ((r_state == StEmpty) || out_ready);
  assign in_ready = w_load ? (4'b0001 << w_grant) : 4'b0000;

  // Only the granted channel is selected, so X on other channels cannot leak through.
  always_comb begin
    w_win_data = in_data0;
    unique case (w_grant)
      2'd0: w_win_data = in_data0;
      2'd1: w_win_data = in_data1;
      2'd2: w_win_data = in_data2;
      2'd3: w_win_data = in_data3;
      default: w_win_data = in_data0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (w_load) begin
      w_state_next = StFull;
    end else if ((r_state == StFull) && out_ready) begin
      w_state_next = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StEmpty;
      r_ptr      <= 2'd3;
      r_out_data <= '0;
      r_out_sel  <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_out_data <= w_win_data;
        r_out_sel  <= w_grant;
        r_ptr      <= w_grant;
      end
    end
  end

  assign out_valid = (r_state == StFull);
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

`ifdef MUX_RR_FEEDER_CNT_EN
  logic [7:0] r_cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_load && (w_grant == 2'(i)) && (r_cnt[i] != 8'hff)) begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < 4; i++) grant_cnt[8*i +: 8] = r_cnt[i];
  end
`endif

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Directed bench for mux_rr_feeder: vector table plus hand sequences for round-robin order,
// X isolation, asynchronous reset and (with MUX_RR_FEEDER_CNT_EN) counter saturation.
module tb_mux_rr_feeder;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
`ifdef MUX_RR_FEEDER_CNT_EN
  logic [31:0]  grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_rr_feeder #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef MUX_RR_FEEDER_CNT_EN
    .grant_cnt (grant_cnt),
`endif
    .out_sel   (out_sel)
  );

  typedef struct {
    logic [3:0] iv;
    logic [3:0] d0, d1, d2, d3;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [3:0] exp_data;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] iv, input logic [3:0] d0, input logic [3:0] d1,
                       input logic [3:0] d2, input logic [3:0] d3, input logic ordy);
    in_valid  = iv;
    in_data0  = d0;
    in_data1  = d1;
    in_data2  = d2;
    in_data3  = d3;
    out_ready = ordy;
  endtask

  // Called at posedge+1: checks in_ready mid-cycle, then registered outputs after the edge.
  task automatic step(input string name, input logic [3:0] exp_rdy, input logic exp_ov,
                      input logic [3:0] exp_data, input logic [1:0] exp_sel);
    #2;
    check({name, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    check({name, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    check({name, ".out_data"}, 32'(out_data), 32'(exp_data));
    check({name, ".out_sel"}, 32'(out_sel), 32'(exp_sel));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    //           iv       d0    d1    d2    d3   ordy  rdy     ov    data  sel
    vecs[0]  = '{4'b0001, 4'ha, 4'h0, 4'h0, 4'h0, 1'b1, 4'b0001, 1'b1, 4'ha, 2'd0};
    vecs[1]  = '{4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 4'ha, 2'd0};
    vecs[2]  = '{4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'b0000, 1'b0, 4'ha, 2'd0};
    vecs[3]  = '{4'b0100, 4'h1, 4'h5, 4'h7, 4'h9, 1'b0, 4'b0100, 1'b1, 4'h7, 2'd2};
    vecs[4]  = '{4'b1011, 4'h1, 4'h5, 4'h7, 4'h9, 1'b0, 4'b0000, 1'b1, 4'h7, 2'd2};
    vecs[5]  = '{4'b1011, 4'h1, 4'h5, 4'h7, 4'h9, 1'b0, 4'b0000, 1'b1, 4'h7, 2'd2};
    vecs[6]  = '{4'b1011, 4'h1, 4'h5, 4'h7, 4'h9, 1'b0, 4'b0000, 1'b1, 4'h7, 2'd2};
    vecs[7]  = '{4'b1011, 4'h1, 4'h5, 4'h7, 4'h9, 1'b1, 4'b1000, 1'b1, 4'h9, 2'd3};
    vecs[8]  = '{4'b1011, 4'h1, 4'h5, 4'h7, 4'h9, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    vecs[9]  = '{4'b1011, 4'h1, 4'h5, 4'h7, 4'h9, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1};
    vecs[10] = '{4'b1011, 4'h1, 4'h5, 4'h7, 4'h9, 1'b1, 4'b1000, 1'b1, 4'h9, 2'd3};
    vecs[11] = '{4'b0010, 4'h0, 4'h5, 4'h0, 4'h0, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1};
    vecs[12] = '{4'b0010, 4'h0, 4'h5, 4'h0, 4'h0, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1};
    vecs[13] = '{4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd1};

    // Reset state, with requests present to show nothing is accepted during reset.
    rst_n = 1'b0;
    drive(4'b1111, 4'ha, 4'hb, 4'hc, 4'hd, 1'b1);
    @(posedge clk);
    #1;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_data", 32'(out_data), 32'd0);
    check("reset.out_sel", 32'(out_sel), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].iv, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].ordy);
      step($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_ov, vecs[i].exp_data,
           vecs[i].exp_sel);
    end

    // All four requesting from reset: 0,1,2,3,0,1,2,3 at one word per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ed;
      drive(4'b1111, 4'ha, 4'hb, 4'hc, 4'hd, 1'b1);
      ed = 4'(4'ha + 4'(i % 4));
      step($sformatf("rr%0d", i), 4'(4'b0001 << (i % 4)), 1'b1, ed, 2'(i % 4));
    end

    // X on non-granted channels must not reach the outputs.
    drive(4'b0100, 4'bxxxx, 4'bxxxx, 4'h3, 4'bxxxx, 1'b1);
    step("xiso", 4'b0100, 1'b1, 4'h3, 2'd2);
    check("xiso.known", 32'($isunknown({out_valid, out_data, out_sel, in_ready})), 32'd0);

    // Asynchronous reset mid-cycle while FULL.
    drive(4'b1111, 4'ha, 4'hb, 4'hc, 4'hd, 1'b1);
    step("pre_arst", 4'b1000, 1'b1, 4'hd, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.out_data", 32'(out_data), 32'd0);
    check("arst.out_sel", 32'(out_sel), 32'd0);
    check("arst.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'b1100, 4'h1, 4'h2, 4'h6, 4'h8, 1'b1);
    step("post_arst", 4'b0100, 1'b1, 4'h6, 2'd2);

`ifdef MUX_RR_FEEDER_CNT_EN
    do_reset();
    drive(4'b0010, 4'h0, 4'h5, 4'h0, 4'h0, 1'b1);
    repeat (300) @(posedge clk);
    #1;
    check("grant_cnt", grant_cnt, 32'h0000_ff00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
